mdr_mem_port: RTL and testbench
===============================

// Module: mdr_mem_port
// PURPOSE
//  Parametrised memory data register with a request/acknowledge memory port for the Mini SRC datapath.
//  - Loads from the internal bus (BusMuxOut) or from memory.
//  - Writes its contents to memory.
//  - Supports variable-latency memory through a wait-state handshake and a timeout.
//  - Sits between the bus mux and the memory subsystem.
//  - The control unit sees busy and done.
// PARAMETERS
//  DATA_WIDTH      32   width of register, bus and memory data
//  TIMEOUT_CYCLES  15   wait cycles without mem_ack before an access is aborted (>=1)
// PORTS
//  clock        in   1           rising-edge clock
//  clear        in   1           synchronous, active-high reset
//  BusMuxOut    in   DATA_WIDTH  internal bus data
//  MDRin        in   1           load strobe: bus load (read=0) or memory read start (read=1)
//  read         in   1           selects memory as the source when MDRin=1
//  write        in   1           start a memory write of the current register value
//  Mdatain      in   DATA_WIDTH  memory read data, valid when mem_ack=1
//  mem_ack      in   1           memory acknowledge, one cycle
//  mem_req      out  1           memory request; held high until ack or timeout
//  mem_we       out  1           1=write, 0=read; valid while mem_req=1
//  mem_wdata    out  DATA_WIDTH  write data, equal to out while a write is pending
//  out          out  DATA_WIDTH  register contents
//  busy         out  1           high in RD_WAIT or WR_WAIT
//  done         out  1           one-cycle pulse when an access completes normally
//  timeout_err  out  1           sticky; set by a timed-out access
// BEHAVIOUR
//  Reset (clear=1 at posedge)
//   - out=0, mem_req=0, mem_we=0, busy=0, done=0, timeout_err=0, wait counter=0, state=IDLE.
//   - Applies in every state and aborts any pending access immediately.
//  Outputs
//   - All outputs are registered.
//   - mem_wdata = out, combinationally.
//  States
//   - IDLE
//     - MDRin=1, read=0: out<=BusMuxOut; state stays IDLE; the bus load takes effect the next cycle.
//     - MDRin=1, read=1: mem_req<=1, mem_we<=0, counter<=0, go to RD_WAIT.
//     - write=1 (and no read start): mem_req<=1, mem_we<=1, counter<=0, go to WR_WAIT.
//     - Simultaneous read start and write: the read wins; the write is dropped.
//     - MDRin=1, read=0 together with write=1: the bus load and the write start in the same cycle. The write carries the OLD value of out, sampled as mem_wdata at the ack cycle... NO: the write carries the newly loaded value, because out holds steady in WR_WAIT.
//     - Starting any access clears timeout_err.
//   - RD_WAIT
//     - mem_ack=1: out<=Mdatain, mem_req<=0, done<=1, go to IDLE.
//     - Otherwise counter increments.
//     - counter==TIMEOUT_CYCLES-1 with no ack: mem_req<=0, timeout_err<=1, out unchanged, go to IDLE, no done pulse.
//   - WR_WAIT
//     - Same as RD_WAIT, except out is never modified.
//  Command handling
//   - MDRin, read and write are ignored while busy=1; there is no queueing.
//   - mem_ack outside RD_WAIT/WR_WAIT is ignored.
//  Latency
//   - Command at edge N gives mem_req=1 after N.
//   - Ack sampled at edge N+1 gives out updated and done=1 after N+1 (2 cycles minimum).
//   - Each memory wait cycle adds 1.
//  Boundaries
//   - An ack in the same edge as the timeout count is accepted as success.
//   - The counter never wraps; its width is ceil(log2(TIMEOUT_CYCLES))+1.
//   - DATA_WIDTH has no arithmetic; widths match exactly, with no extension or truncation.
// CONFIGURATION
//  MDR_PARITY_EN defined
//   - Adds input mem_parity (1) and output parity_err (1, sticky, reset 0).
//   - On a read ack, parity_err<=1 if ^Mdatain != mem_parity (even parity).
//   - Data is still loaded when parity mismatches.
//   - parity_err is cleared only by clear.
//  MDR_PARITY_EN not defined
//   - The ports and the logic are absent.
// TESTING
//  - Reset: set clear=1 for 1 cycle mid RD_WAIT -> next cycle out=0, mem_req=0, busy=0, timeout_err=0.
//  - Bus load: BusMuxOut=32'hDEADBEEF, MDRin=1, read=0 -> out=32'hDEADBEEF next cycle; mem_req stays 0.
//  - Read with 3 wait states: MDRin=1, read=1; ack on the 4th RD_WAIT cycle with Mdatain=32'h12345678 -> out=32'h12345678, done high 1 cycle, busy low.
//  - Write: out=32'hA5A5A5A5, write=1, ack after 1 wait -> mem_we=1 and mem_wdata=32'hA5A5A5A5 throughout the request; out unchanged; done pulse.
//  - Timeout: read with no ack -> after TIMEOUT_CYCLES cycles mem_req=0, timeout_err=1, out unchanged, no done; the next write clears timeout_err.
//  - Conflict and parity: read and write together in IDLE -> only the read is issued (mem_we=0). With MDR_PARITY_EN, ack Mdatain=32'h1 with mem_parity=0 -> parity_err=1 and out=32'h1.

Source files
------------

// File: rtl/mdr_mem_port.sv
// rtl/mdr_mem_port.sv - Mini SRC memory data register with req/ack memory port and wait timeout
// Optional even-parity check of memory read data is enabled by defining MDR_PARITY_EN.
module mdr_mem_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MDRin,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] Mdatain,
  input  logic                  mem_ack,
`ifdef MDR_PARITY_EN
  input  logic                  mem_parity,
  output logic                  parity_err,
`endif
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_out, w_out_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_req, w_req_nxt;
  logic                  r_we, w_we_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_terr, w_terr_nxt;
`ifdef MDR_PARITY_EN
  logic                  r_perr, w_perr_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_done_nxt  = 1'b0;
    w_terr_nxt  = r_terr;
`ifdef MDR_PARITY_EN
    w_perr_nxt  = r_perr;
`endif
    case (r_state)
      S_IDLE: begin
        if (MDRin && read) begin
          w_state_nxt = S_RD_WAIT;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_terr_nxt  = 1'b0;
        end else begin
          if (MDRin) w_out_nxt = BusMuxOut;
          // A write started with a bus load carries the new value: out is frozen in WR_WAIT.
          if (write) begin
            w_state_nxt = S_WR_WAIT;
            w_req_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
            w_cnt_nxt   = '0;
            w_terr_nxt  = 1'b0;
          end
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (mem_ack) begin
          if (r_state == S_RD_WAIT) begin
            w_out_nxt = Mdatain;
`ifdef MDR_PARITY_EN
            if ((^Mdatain) != mem_parity) w_perr_nxt = 1'b1;
`endif
          end
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == LAST_WAIT) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_terr_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_terr  <= 1'b0;
`ifdef MDR_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_terr  <= w_terr_nxt;
`ifdef MDR_PARITY_EN
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  assign out         = r_out;
  assign mem_wdata   = r_out;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_terr;
`ifdef MDR_PARITY_EN
  assign parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_mdr_mem_port.sv
// tb/tb_mdr_mem_port.sv - self-checking bench for mdr_mem_port: directed literals plus random traffic
// Parity ports and checks are included when MDR_PARITY_EN is defined.
module tb_mdr_mem_port;

  localparam int DW = 32;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear;
  logic [DW-1:0] BusMuxOut;
  logic          MDRin;
  logic          read;
  logic          write;
  logic [DW-1:0] Mdatain;
  logic          mem_ack;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] out;
  logic          busy;
  logic          done;
  logic          timeout_err;
`ifdef MDR_PARITY_EN
  logic          mem_parity;
  logic          parity_err;
  bit            m_perr;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: which access is outstanding and how long it has waited.
  int            m_kind;   // 0 none, 1 read, 2 write
  int            m_waited;
  logic [DW-1:0] m_out;
  bit            m_done;
  bit            m_terr;

  always #5 clock = ~clock;

  mdr_mem_port #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MDRin       (MDRin),
    .read        (read),
    .write       (write),
    .Mdatain     (Mdatain),
    .mem_ack     (mem_ack),
`ifdef MDR_PARITY_EN
    .mem_parity  (mem_parity),
    .parity_err  (parity_err),
`endif
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    m_done = 1'b0;
    if (clear) begin
      m_kind = 0; m_waited = 0; m_out = '0; m_terr = 1'b0;
`ifdef MDR_PARITY_EN
      m_perr = 1'b0;
`endif
    end else if (m_kind == 0) begin
      if (MDRin && read) begin
        m_kind = 1; m_waited = 0; m_terr = 1'b0;
      end else begin
        if (MDRin) m_out = BusMuxOut;
        if (write) begin
          m_kind = 2; m_waited = 0; m_terr = 1'b0;
        end
      end
    end else if (mem_ack) begin
      if (m_kind == 1) begin
        m_out = Mdatain;
`ifdef MDR_PARITY_EN
        if ($countones(Mdatain) % 2 != int'(mem_parity)) m_perr = 1'b1;
`endif
      end
      m_done = 1'b1;
      m_kind = 0;
    end else begin
      m_waited++;
      if (m_waited >= TO) begin
        m_terr = 1'b1;
        m_kind = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("out", out, m_out);
      check("mem_wdata", mem_wdata, m_out);
      check("mem_req", mem_req, m_kind != 0);
      check("busy", busy, m_kind != 0);
      check("done", done, m_done);
      check("timeout_err", timeout_err, m_terr);
      if (m_kind != 0) check("mem_we", mem_we, m_kind == 2);
`ifdef MDR_PARITY_EN
      check("parity_err", parity_err, m_perr);
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    MDRin = 0; read = 0; write = 0; mem_ack = 0;
  endtask

  initial begin
    clear = 1; BusMuxOut = '0; Mdatain = '0;
    idle_inputs();
`ifdef MDR_PARITY_EN
    mem_parity = 0;
`endif
    step();
    chk_en = 1'b1;
    step();
    clear = 0;
    check("reset_out", out, 32'h0);
    check("reset_req", mem_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_terr", timeout_err, 1'b0);

    // Bus load
    BusMuxOut = 32'hDEADBEEF; MDRin = 1; step(); MDRin = 0;
    check("busload_out", out, 32'hDEADBEEF);
    check("busload_req", mem_req, 1'b0);
    check("model_busload", m_out, 32'hDEADBEEF);

    // Read with 3 wait states, ack on the 4th RD_WAIT cycle
    MDRin = 1; read = 1; step(); MDRin = 0; read = 0;
    check("rd_req", mem_req, 1'b1);
    check("rd_we", mem_we, 1'b0);
    check("rd_busy", busy, 1'b1);
    repeat (3) step();
    check("rd_still_busy", busy, 1'b1);
    mem_ack = 1; Mdatain = 32'h12345678; step(); mem_ack = 0;
    check("rd_out", out, 32'h12345678);
    check("rd_done", done, 1'b1);
    check("rd_busy_low", busy, 1'b0);
    step();
    check("rd_done_pulse", done, 1'b0);

    // Write with one wait state
    BusMuxOut = 32'hA5A5A5A5; MDRin = 1; step(); MDRin = 0;
    write = 1; step(); write = 0;
    check("wr_we", mem_we, 1'b1);
    check("wr_wdata0", mem_wdata, 32'hA5A5A5A5);
    step();
    check("wr_wdata1", mem_wdata, 32'hA5A5A5A5);
    check("wr_req1", mem_req, 1'b1);
    mem_ack = 1; Mdatain = 32'h0BADF00D; step(); mem_ack = 0;
    check("wr_done", done, 1'b1);
    check("wr_out", out, 32'hA5A5A5A5);

    // Timeout on a read with no ack
    MDRin = 1; read = 1; step(); MDRin = 0; read = 0;
    repeat (TO - 1) step();
    check("to_req_before", mem_req, 1'b1);
    check("to_terr_before", timeout_err, 1'b0);
    step();
    check("to_req", mem_req, 1'b0);
    check("to_terr", timeout_err, 1'b1);
    check("to_done", done, 1'b0);
    check("to_out", out, 32'hA5A5A5A5);
    check("model_terr", m_terr, 1'b1);
    write = 1; step(); write = 0;
    check("to_cleared", timeout_err, 1'b0);
    mem_ack = 1; step(); mem_ack = 0;

    // Ack on the very cycle the timeout would fire
    MDRin = 1; read = 1; step(); MDRin = 0; read = 0;
    repeat (TO - 1) step();
    mem_ack = 1; Mdatain = 32'hCAFEF00D; step(); mem_ack = 0;
    check("edge_done", done, 1'b1);
    check("edge_terr", timeout_err, 1'b0);
    check("edge_out", out, 32'hCAFEF00D);

    // Read and write together: read wins
    BusMuxOut = 32'h11; MDRin = 1; read = 1; write = 1; step(); idle_inputs();
    check("conf_we", mem_we, 1'b0);
    check("conf_req", mem_req, 1'b1);
    mem_ack = 1; Mdatain = 32'h1;
`ifdef MDR_PARITY_EN
    mem_parity = 0;
`endif
    step(); mem_ack = 0;
    check("conf_out", out, 32'h1);
`ifdef MDR_PARITY_EN
    check("parity_err", parity_err, 1'b1);
`endif

    // Reset in the middle of RD_WAIT
    MDRin = 1; read = 1; step(); idle_inputs();
    step();
    clear = 1; step(); clear = 0;
    check("mid_rst_out", out, 32'h0);
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_terr", timeout_err, 1'b0);

    // Random traffic with varying memory responsiveness
    for (int seg = 0; seg < 6; seg++) begin
      int ack_pct;
      ack_pct = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 30 : 75);
      for (int c = 0; c < 500; c++) begin
        clear     = ($urandom_range(0, 199) == 0);
        MDRin     = ($urandom_range(0, 3) == 0);
        read      = $urandom_range(0, 1);
        write     = ($urandom_range(0, 3) == 0);
        mem_ack   = ($urandom_range(0, 99) < ack_pct);
        BusMuxOut = $urandom;
        Mdatain   = $urandom;
`ifdef MDR_PARITY_EN
        mem_parity = $urandom_range(0, 1);
`endif
        step();
      end
    end
    idle_inputs();
    clear = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
